// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST miscompare logger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bist_pkg;

    // Controller state encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_CAPTURE = S_CAPTURE,
        ST_DRAIN   = S_DRAIN,
        ST_DONE    = S_DONE
    } state_t;

    // Default geometry of the logged entry {addr, elem, syndrome}
    localparam int ADDR_W_DEF = 8;
    localparam int ELEM_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    function automatic int log_entry_w(input int addr_w, input int elem_w, input int data_w);
        return addr_w + elem_w + data_w;
    endfunction

    localparam int LOG_W_DEF = ADDR_W_DEF + ELEM_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/bist_fail_fifo.sv
// Synchronous FIFO holding logged miscompare entries; clear empties it in one cycle.
// Latency: push at edge N is visible at pop_dat after edge N; pop_dat is the registered head.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module bist_fail_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a full FIFO can still take the push.
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally (DEPTH is a power of 2); occupancy tells full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents behind the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/bist_fail_logger.sv
// Logs BIST miscompares {addr, elem, exp^act} into a FIFO and tracks run status flags.
// Latency: a miscompare at edge N shows on log_*/fail_count/bist_fail after edge N.
// Backpressure: host stalls with log_ready=0; when the log is full further fails are counted but dropped.
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ELEM_W = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [ELEM_W-1:0] cmp_elem,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] cmp_act,
    input  logic              bist_done,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [ELEM_W-1:0] log_elem,
    output logic [DATA_W-1:0] log_syndrome,
    output logic [CNT_W-1:0]  fail_count,
    output logic              log_overflow,
    output logic              bist_fail,
    output logic              report_done
);
    localparam int LOG_W = log_entry_w(ADDR_W, ELEM_W, DATA_W);
    localparam int CNT_FW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ELEM_W-1:0] elem;
        logic [DATA_W-1:0] syndrome;
    } log_entry_t;

    state_t           state;
    log_entry_t       push_entry;
    log_entry_t       head_entry;
    logic [LOG_W-1:0] head_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_FW-1:0] fifo_count;
    logic             fail;
    logic             pop;
    logic             overflow_evt;
    logic             drain_empty;

    // A start cycle is an abort/clear cycle, so any compare alongside it is ignored.
    assign fail         = (state == ST_CAPTURE) & ~start & cmp_valid & (cmp_exp != cmp_act);
    assign log_valid    = ~fifo_empty & (state != ST_IDLE);
    assign pop          = log_valid & log_ready;
    assign overflow_evt = fail & fifo_full & ~pop;
    // Empty now, or the last entry leaves at this edge.
    assign drain_empty  = fifo_empty | ((fifo_count == CNT_FW'(1)) & pop);

    assign push_entry.addr     = cmp_addr;
    assign push_entry.elem     = cmp_elem;
    assign push_entry.syndrome = cmp_exp ^ cmp_act;

    assign head_entry   = log_entry_t'(head_dat);
    assign log_addr     = log_valid ? head_entry.addr     : '0;
    assign log_elem     = log_valid ? head_entry.elem     : '0;
    assign log_syndrome = log_valid ? head_entry.syndrome : '0;

    bist_fail_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .push     (fail),
        .push_dat (push_entry),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Run controller with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            fail_count   <= '0;
            bist_fail    <= 1'b0;
            log_overflow <= 1'b0;
            report_done  <= 1'b0;
        end else if (start) begin
            state        <= ST_CAPTURE;
            fail_count   <= '0;
            bist_fail    <= 1'b0;
            log_overflow <= 1'b0;
            report_done  <= 1'b0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (fail) begin
                        bist_fail <= 1'b1;
                        if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    end
                    if (overflow_evt) log_overflow <= 1'b1;
                    if (bist_done)    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state       <= ST_DONE;
                        report_done <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_fail_logger.sv
module tb_bist_fail_logger;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cmp_valid;
    logic [7:0] cmp_addr;
    logic [2:0] cmp_elem;
    logic [7:0] cmp_exp;
    logic [7:0] cmp_act;
    logic       bist_done;
    logic       log_valid;
    logic       log_ready;
    logic [7:0] log_addr;
    logic [2:0] log_elem;
    logic [7:0] log_syndrome;
    logic [15:0] fail_count;
    logic       log_overflow;
    logic       bist_fail;
    logic       report_done;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    bist_fail_logger dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cmp_valid    (cmp_valid),
        .cmp_addr     (cmp_addr),
        .cmp_elem     (cmp_elem),
        .cmp_exp      (cmp_exp),
        .cmp_act      (cmp_act),
        .bist_done    (bist_done),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_addr     (log_addr),
        .log_elem     (log_elem),
        .log_syndrome (log_syndrome),
        .fail_count   (fail_count),
        .log_overflow (log_overflow),
        .bist_fail    (bist_fail),
        .report_done  (report_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        exp_q.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        bist_done = 1'b1;
        tick();
        bist_done = 1'b0;
    endtask

    task automatic do_cmp(input logic [7:0] a, input logic [2:0] e, input logic [7:0] x,
                          input logic [7:0] y, input logic done, input logic logged);
        cmp_valid = 1'b1;
        cmp_addr  = a;
        cmp_elem  = e;
        cmp_exp   = x;
        cmp_act   = y;
        bist_done = done;
        if (logged) exp_q.push_back({a, e, x ^ y});
        tick();
        cmp_valid = 1'b0;
        bist_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !report_done) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL %s_timeout: pending=%0d report_done=%0b required pending=0 report_done=1",
                     name, exp_q.size(), report_done);
        end
    endtask

    // Scoreboard monitor: compares each accepted head entry and checks head stability under stall.
    initial begin
        logic [18:0] held = '0;
        logic        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_vld = 1'b0;
            end else begin
                if (held_vld && log_valid)
                    check("head_stable", {log_addr, log_elem, log_syndrome}, held);
                if (log_valid && log_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_entry: got 0x%0h with nothing expected",
                                 {log_addr, log_elem, log_syndrome});
                    end else begin
                        check("entry", {log_addr, log_elem, log_syndrome}, exp_q.pop_front());
                    end
                    held_vld = 1'b0;
                end else if (log_valid) begin
                    held     = {log_addr, log_elem, log_syndrome};
                    held_vld = 1'b1;
                end else begin
                    held_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cmp_valid = 1'b0; cmp_addr = '0; cmp_elem = '0;
        cmp_exp = '0; cmp_act = '0; bist_done = 1'b0; log_ready = 1'b1;
        repeat (3) tick();
        check("rst_log_valid", log_valid, 0);
        check("rst_log_data", {log_addr, log_elem, log_syndrome}, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_flags", {bist_fail, log_overflow, report_done}, 0);
        rst_n = 1'b1;
        tick();

        // 1: 64 matching compares
        pulse_start();
        for (int i = 0; i < 64; i++) do_cmp(8'(i), 3'(i % 8), 8'(i * 3), 8'(i * 3), 1'b0, 1'b0);
        pulse_done();
        check("t1_report_done_drain", report_done, 0);
        tick();
        check("t1_report_done", report_done, 1);
        check("t1_bist_fail", bist_fail, 0);
        check("t1_fail_count", fail_count, 0);
        check("t1_log_valid", log_valid, 0);

        // 2: two fails, host always ready
        pulse_start();
        check("t2_start_clears_done", report_done, 0);
        do_cmp(8'h05, 3'd2, 8'h55, 8'h57, 1'b0, 1'b1);
        do_cmp(8'h80, 3'd4, 8'hAA, 8'h2A, 1'b0, 1'b1);
        pulse_done();
        wait_drain("t2");
        check("t2_fail_count", fail_count, 2);
        check("t2_bist_fail", bist_fail, 1);
        check("t2_overflow", log_overflow, 0);

        // 3: overflow with host stalled
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            do_cmp(8'(8'h10 + i), 3'(i), 8'h00, 8'(i + 1), 1'b0, i < 8);
        check("t3_overflow", log_overflow, 1);
        check("t3_fail_count", fail_count, 10);
        check("t3_log_valid", log_valid, 1);
        check("t3_head_addr", log_addr, 8'h10);
        pulse_done();
        log_ready = 1'b1;
        wait_drain("t3");

        // 4: full FIFO with simultaneous pop accepts the push
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            do_cmp(8'(8'h20 + i), 3'(i), 8'hF0, 8'(8'hF0 ^ (1 << i)), 1'b0, 1'b1);
        check("t4_full_occ", dut.u_fifo.count, 8);
        log_ready = 1'b1;
        do_cmp(8'h28, 3'd7, 8'h0F, 8'h0E, 1'b0, 1'b1);
        log_ready = 1'b0;
        check("t4_occ_after", dut.u_fifo.count, 8);
        check("t4_overflow", log_overflow, 0);
        check("t4_fail_count", fail_count, 9);
        check("t4_head_addr", log_addr, 8'h21);
        log_ready = 1'b1;
        pulse_done();
        wait_drain("t4");

        // 5: fail coincident with bist_done, host stalls 5 cycles
        pulse_start();
        log_ready = 1'b0;
        do_cmp(8'h3C, 3'd5, 8'h0F, 8'hF0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", log_valid, 1);
            check("t5_hold_no_done", report_done, 0);
            tick();
        end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check("t5_report_done", report_done, 1);
        check("t5_log_valid", log_valid, 0);
        check("t5_fail_count", fail_count, 1);

        // 6: abort mid-capture, then reset during drain
        pulse_start();
        for (int i = 0; i < 3; i++) do_cmp(8'(8'h40 + i), 3'd1, 8'h11, 8'h10, 1'b0, 1'b1);
        check("t6_queued_valid", log_valid, 1);
        pulse_start();
        check("t6_abort_valid", log_valid, 0);
        check("t6_abort_count", fail_count, 0);
        check("t6_abort_flags", {bist_fail, log_overflow, report_done}, 0);
        do_cmp(8'h77, 3'd3, 8'h01, 8'h03, 1'b1, 1'b1);
        check("t6_drain_valid", log_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("t6_rst_valid", log_valid, 0);
        check("t6_rst_data", {log_addr, log_elem, log_syndrome}, 0);
        check("t6_rst_count", fail_count, 0);
        check("t6_rst_flags", {bist_fail, log_overflow, report_done}, 0);
        rst_n = 1'b1;
        log_ready = 1'b1;
        do_cmp(8'h99, 3'd0, 8'h00, 8'hFF, 1'b0, 1'b0);
        check("t6_idle_ignores_count", fail_count, 0);
        check("t6_idle_ignores_valid", log_valid, 0);
        repeat (2) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
